// File: rtl/reg_file_pkg.sv
// Shared definitions for the register file: default geometry and ABI register indices.
// Combinational-only content; nothing here holds state.
package reg_file_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  // ABI register names for the 32-entry configuration
  localparam int ZERO = 0;
  localparam int AT   = 1;
  localparam int V0   = 2;
  localparam int V1   = 3;
  localparam int A0   = 4;
  localparam int A1   = 5;
  localparam int A2   = 6;
  localparam int A3   = 7;
  localparam int T0   = 8;
  localparam int T1   = 9;
  localparam int T2   = 10;
  localparam int T3   = 11;
  localparam int T4   = 12;
  localparam int T5   = 13;
  localparam int T6   = 14;
  localparam int T7   = 15;
  localparam int S0   = 16;
  localparam int S1   = 17;
  localparam int S2   = 18;
  localparam int S3   = 19;
  localparam int S4   = 20;
  localparam int S5   = 21;
  localparam int S6   = 22;
  localparam int S7   = 23;
  localparam int T8   = 24;
  localparam int T9   = 25;
  localparam int K0   = 26;
  localparam int K1   = 27;
  localparam int GP   = 28;
  localparam int SP   = 29;
  localparam int FP   = 30;
  localparam int RA   = 31;

  // True when idx names the hardwired zero register in this configuration
  function automatic logic is_zero_idx(input logic [31:0] idx, input int zero_reg);
    return (zero_reg != 0) && (idx == 32'd0);
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy flags: set on issue, cleared on writeback, set wins on a shared edge.
// Lookups are combinational (zero latency); no backpressure, every event is accepted.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     set_en,
  input  logic [ADDR_W-1:0]        set_idx,
  input  logic                     clr_en,
  input  logic [ADDR_W-1:0]        clr_idx,
  input  logic [NUM_RD*ADDR_W-1:0] look_idx,
  output logic [NUM_RD-1:0]        look_busy,
  output logic                     any_busy
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic             set_ok;

  // Clear first, then set, so a new producer issued on the writeback edge keeps the flag
  always_comb begin
    set_ok   = set_en && !is_zero_idx(32'(set_idx), ZERO_REG);
    busy_nxt = busy;
    if (clr_en) begin
      busy_nxt[clr_idx] = 1'b0;
    end
    if (set_ok) begin
      busy_nxt[set_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_look
    assign look_busy[k] = busy[look_idx[k*ADDR_W +: ADDR_W]];
  end

  assign any_busy = |busy;

endmodule

// File: rtl/reg_file_sb.sv
// Multi-read-port register file with write-to-read bypass and a busy scoreboard.
// Reads are combinational (zero latency); writes/issues land on posedge; never stalls.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     WrEn,
  input  logic [ADDR_W-1:0]        WrReg,
  input  logic [DATA_W-1:0]        WrData,
  input  logic                     IssueEn,
  input  logic [ADDR_W-1:0]        IssueReg,
  input  logic [NUM_RD*ADDR_W-1:0] RdReg,
  output logic [NUM_RD*DATA_W-1:0] RdData,
  output logic [NUM_RD-1:0]        RdBusy,
  output logic                     AnyBusy
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              wr_ok;
  logic [NUM_RD-1:0] sb_busy;

  assign wr_ok = WrEn && !is_zero_idx(32'(WrReg), ZERO_REG);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[WrReg] <= WrData;
    end
  end

  reg_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .set_en    (IssueEn),
    .set_idx   (IssueReg),
    .clr_en    (wr_ok),
    .clr_idx   (WrReg),
    .look_idx  (RdReg),
    .look_busy (sb_busy),
    .any_busy  (AnyBusy)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] idx;
    logic              is_zero;
    logic              hit;

    assign idx     = RdReg[k*ADDR_W +: ADDR_W];
    assign is_zero = is_zero_idx(32'(idx), ZERO_REG);
    // The in-flight writeback satisfies the read, so the register is no longer pending for it
    assign hit     = (BYPASS != 0) && WrEn && (idx == WrReg);

    assign RdData[k*DATA_W +: DATA_W] = is_zero ? '0 : (hit ? WrData : regs[idx]);
    assign RdBusy[k]                  = !is_zero && !hit && sb_busy[k];
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed plus random checks of reg_file_sb against an array-based reference model.
module tb_reg_file_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default geometry, shared by a bypassing and a non-bypassing instance
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_reg = '0;
  logic [31:0] wr_data = '0;
  logic        iss_en = 1'b0;
  logic [4:0]  iss_reg = '0;
  logic [9:0]  rd_reg = '0;
  logic [63:0] rd_data_a, rd_data_b;
  logic [1:0]  rd_busy_a, rd_busy_b;
  logic        any_a, any_b;

  // Narrow three-port instance
  logic        p_rst = 1'b0;
  logic        p_wr_en = 1'b0;
  logic [3:0]  p_wr_reg = '0;
  logic [15:0] p_wr_data = '0;
  logic        p_iss_en = 1'b0;
  logic [3:0]  p_iss_reg = '0;
  logic [11:0] p_rd_reg = '0;
  logic [47:0] p_rd_data;
  logic [2:0]  p_rd_busy;
  logic        p_any;

  reg_file_sb dut_a (
    .clk(clk), .rst(rst), .WrEn(wr_en), .WrReg(wr_reg), .WrData(wr_data),
    .IssueEn(iss_en), .IssueReg(iss_reg), .RdReg(rd_reg),
    .RdData(rd_data_a), .RdBusy(rd_busy_a), .AnyBusy(any_a)
  );

  reg_file_sb #(.BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .WrEn(wr_en), .WrReg(wr_reg), .WrData(wr_data),
    .IssueEn(iss_en), .IssueReg(iss_reg), .RdReg(rd_reg),
    .RdData(rd_data_b), .RdBusy(rd_busy_b), .AnyBusy(any_b)
  );

  reg_file_sb #(.DATA_W(16), .ADDR_W(4), .NUM_RD(3)) dut_p (
    .clk(clk), .rst(p_rst), .WrEn(p_wr_en), .WrReg(p_wr_reg), .WrData(p_wr_data),
    .IssueEn(p_iss_en), .IssueReg(p_iss_reg), .RdReg(p_rd_reg),
    .RdData(p_rd_data), .RdBusy(p_rd_busy), .AnyBusy(p_any)
  );

  // Reference state
  logic [31:0] m_reg [32];
  bit   [31:0] m_busy;
  logic [15:0] p_reg [16];
  bit   [15:0] p_busy;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input logic [4:0] idx, input bit byp);
    if (idx == 5'd0) return 32'd0;
    if (byp && wr_en && idx == wr_reg) return wr_data;
    return m_reg[idx];
  endfunction

  function automatic logic exp_busy(input logic [4:0] idx, input bit byp);
    if (idx == 5'd0) return 1'b0;
    if (byp && wr_en && idx == wr_reg) return 1'b0;
    return m_busy[idx];
  endfunction

  function automatic logic [15:0] p_exp_data(input logic [3:0] idx);
    if (idx == 4'd0) return 16'd0;
    if (p_wr_en && idx == p_wr_reg) return p_wr_data;
    return p_reg[idx];
  endfunction

  function automatic logic p_exp_busy(input logic [3:0] idx);
    if (idx == 4'd0) return 1'b0;
    if (p_wr_en && idx == p_wr_reg) return 1'b0;
    return p_busy[idx];
  endfunction

  task automatic check_all(input string tag);
    for (int k = 0; k < 2; k++) begin
      logic [4:0] idx;
      idx = rd_reg[k*5 +: 5];
      check($sformatf("%s/a_data%0d", tag, k), 64'(rd_data_a[k*32 +: 32]), 64'(exp_data(idx, 1'b1)));
      check($sformatf("%s/a_busy%0d", tag, k), 64'(rd_busy_a[k]), 64'(exp_busy(idx, 1'b1)));
      check($sformatf("%s/b_data%0d", tag, k), 64'(rd_data_b[k*32 +: 32]), 64'(exp_data(idx, 1'b0)));
      check($sformatf("%s/b_busy%0d", tag, k), 64'(rd_busy_b[k]), 64'(exp_busy(idx, 1'b0)));
    end
    check({tag, "/a_any"}, 64'(any_a), 64'(m_busy != 0));
    check({tag, "/b_any"}, 64'(any_b), 64'(m_busy != 0));
  endtask

  task automatic check_p(input string tag);
    for (int k = 0; k < 3; k++) begin
      logic [3:0] idx;
      idx = p_rd_reg[k*4 +: 4];
      check($sformatf("%s/p_data%0d", tag, k), 64'(p_rd_data[k*16 +: 16]), 64'(p_exp_data(idx)));
      check($sformatf("%s/p_busy%0d", tag, k), 64'(p_rd_busy[k]), 64'(p_exp_busy(idx)));
    end
    check({tag, "/p_any"}, 64'(p_any), 64'(p_busy != 0));
  endtask

  // Advance the model by the events presented this cycle, then take the clock edge
  task automatic tick();
    if (rst) begin
      for (int i = 0; i < 32; i++) m_reg[i] = '0;
      m_busy = '0;
    end else begin
      if (wr_en && wr_reg != 0) begin
        m_reg[wr_reg]  = wr_data;
        m_busy[wr_reg] = 1'b0;
      end
      if (iss_en && iss_reg != 0) m_busy[iss_reg] = 1'b1;
    end
    if (p_rst) begin
      for (int i = 0; i < 16; i++) p_reg[i] = '0;
      p_busy = '0;
    end else begin
      if (p_wr_en && p_wr_reg != 0) begin
        p_reg[p_wr_reg]  = p_wr_data;
        p_busy[p_wr_reg] = 1'b0;
      end
      if (p_iss_en && p_iss_reg != 0) p_busy[p_iss_reg] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; iss_en = 1'b0; rst = 1'b0;
    p_wr_en = 1'b0; p_iss_en = 1'b0; p_rst = 1'b0;
  endtask

  task automatic wr(input logic [4:0] r, input logic [31:0] d);
    idle();
    wr_en = 1'b1; wr_reg = r; wr_data = d;
    tick();
    idle();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    for (int i = 0; i < 16; i++) p_reg[i] = '0;
    m_busy = '0;
    p_busy = '0;

    // Reset both default instances and the narrow one
    rst = 1'b1; p_rst = 1'b1;
    tick();
    idle();
    rd_reg = {5'd31, 5'd1};
    #1 check_all("reset");
    check_p("p_reset");

    // Preload, issue, then reset with a coincident write to reg 5
    wr(5'd5, 32'h5555_0005);
    wr(5'd8, 32'h0808_0808);
    iss_en = 1'b1; iss_reg = 5'd12;
    tick();
    idle();
    rst = 1'b1; wr_en = 1'b1; wr_reg = 5'd5; wr_data = 32'hAAAA_AAAA;
    tick();
    idle();
    rd_reg = {5'd12, 5'd5};
    #1 check_all("rst_drop");
    check({"rst_drop/reg5"}, 64'(rd_data_a[31:0]), 64'd0);

    // Write then read on both ports
    wr(5'd8, 32'hDEAD_BEEF);
    rd_reg = {5'd8, 5'd8};
    #1 check_all("wr_rd");
    check("wr_rd/p1", 64'(rd_data_a[63:32]), 64'hDEAD_BEEF);
    wr(5'd0, 32'h0000_1234);
    rd_reg = {5'd0, 5'd0};
    #1 check_all("wr_zero");

    // Bypass: value visible before the edge only on the bypassing instance
    wr_en = 1'b1; wr_reg = 5'd9; wr_data = 32'h1234_5678;
    rd_reg = {5'd8, 5'd9};
    #1 check_all("bypass_pre");
    check("bypass_pre/a", 64'(rd_data_a[31:0]), 64'h1234_5678);
    check("bypass_pre/b", 64'(rd_data_b[31:0]), 64'd0);
    tick();
    idle();
    #1 check_all("bypass_post");

    // Scoreboard set/clear and simultaneous write+issue
    iss_en = 1'b1; iss_reg = 5'd10;
    tick();
    idle();
    rd_reg = {5'd10, 5'd10};
    #1 check_all("issue");
    check("issue/busy", 64'(rd_busy_a), 64'd3);
    wr(5'd10, 32'h0000_00A0);
    #1 check_all("clear");
    wr_en = 1'b1; wr_reg = 5'd10; wr_data = 32'h0000_00A1;
    iss_en = 1'b1; iss_reg = 5'd10;
    tick();
    idle();
    #1 check_all("wr_iss_same");
    check("wr_iss_same/busy", 64'(rd_busy_a[0]), 64'd1);
    wr_en = 1'b1; wr_reg = 5'd3; wr_data = 32'h0000_0033;
    iss_en = 1'b1; iss_reg = 5'd4;
    rd_reg = {5'd4, 5'd3};
    tick();
    idle();
    #1 check_all("wr_iss_diff");
    iss_en = 1'b1; iss_reg = 5'd4;
    tick();
    wr(5'd4, 32'h0000_0044);
    #1 check_all("reissue_one_clear");

    // Zero register and top/neighbour indices
    iss_en = 1'b1; iss_reg = 5'd0;
    tick();
    idle();
    rd_reg = {5'd0, 5'd0};
    #1 check_all("issue_zero");
    wr(5'd30, 32'h3030_3030);
    wr(5'd31, 32'hFFFF_FFFF);
    rd_reg = {5'd30, 5'd31};
    #1 check_all("edge_idx");
    check("edge_idx/r31", 64'(rd_data_a[31:0]), 64'hFFFF_FFFF);
    check("edge_idx/r30", 64'(rd_data_a[63:32]), 64'h3030_3030);

    // Narrow instance: three packed ports and reset over an outstanding issue
    p_wr_en = 1'b1; p_wr_reg = 4'd1; p_wr_data = 16'hA5A5;
    tick();
    idle();
    p_wr_en = 1'b1; p_wr_reg = 4'd15; p_wr_data = 16'h5A5A;
    tick();
    idle();
    p_rd_reg = {4'd1, 4'd15, 4'd1};
    #1 check_p("p_three");
    check("p_three/slices", 64'(p_rd_data), 64'hA5A5_5A5A_A5A5);
    p_iss_en = 1'b1; p_iss_reg = 4'd15;
    tick();
    idle();
    #1 check_p("p_issue");
    p_rst = 1'b1;
    tick();
    idle();
    #1 check_p("p_rst_busy");

    // Random traffic on all instances
    for (int n = 0; n < 400; n++) begin
      idle();
      rst     = ($urandom_range(0, 49) == 0);
      wr_en   = $urandom_range(0, 1) == 1;
      wr_reg  = 5'($urandom_range(0, 31));
      wr_data = $urandom;
      iss_en  = $urandom_range(0, 2) != 0;
      iss_reg = ($urandom_range(0, 3) == 0) ? wr_reg : 5'($urandom_range(0, 31));
      for (int k = 0; k < 2; k++)
        rd_reg[k*5 +: 5] = ($urandom_range(0, 2) == 0) ? wr_reg : 5'($urandom_range(0, 31));
      p_rst     = ($urandom_range(0, 49) == 0);
      p_wr_en   = $urandom_range(0, 1) == 1;
      p_wr_reg  = 4'($urandom_range(0, 15));
      p_wr_data = 16'($urandom);
      p_iss_en  = $urandom_range(0, 2) != 0;
      p_iss_reg = 4'($urandom_range(0, 15));
      for (int k = 0; k < 3; k++)
        p_rd_reg[k*4 +: 4] = ($urandom_range(0, 2) == 0) ? p_wr_reg : 4'($urandom_range(0, 15));
      #1;
      if (!rst) check_all($sformatf("rand%0d", n));
      if (!p_rst) check_p($sformatf("prand%0d", n));
      tick();
    end

    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
